// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: latches the access, handshakes with a word memory, and extends load data.
// Latency: 3 cycles per access with zero memory wait states (request, WAIT, DONE); +1 per wait state.
// Backpressure: Stall holds the core from request until DONE; the access aborts after TIMEOUT_CYCLES.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned h/w accesses instead of aligning them down.
module lsu_mem_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [31:0]           WriteData,
   output logic [31:0]           ReadData,
   output logic                  Stall,
   output logic                  BusErr,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic [31:0]           mem_rdata
);

   // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires on that WAIT cycle.
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    acc_f3;
   logic [1:0]    acc_lo;
   logic          req;
   logic          misalign;
   logic          timeout_hit;
   logic [3:0]    st_be;
   logic [31:0]   st_data;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;

   assign req         = MemRead | MemWrite;
   assign timeout_hit = (state == WAIT) && !mem_ready && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
   // Halfword (lh/lhu/sh) on an odd byte, or word on a non-word boundary.
   assign misalign = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                     ((funct3 == 3'b010) && (ALUResult[1:0] != 2'b00));
`else
   // Low address bits beyond the access size are simply ignored (aligned down).
   assign misalign = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; DONE always returns to IDLE so a held request is not re-issued.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = misalign ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (mem_ready || timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Core stall: combinational so the core freezes in the same cycle the request appears.
   always_comb begin
      Stall = 1'b0;
      if (((state == IDLE) && req) || (state == WAIT)) begin
         Stall = 1'b1;
      end
   end

   // Byte enables and lane-replicated store data from access size and low address bits.
   always_comb begin
      st_be   = 4'b1111;
      st_data = WriteData;
      case (funct3[1:0])
         2'b00: begin
            st_be   = 4'b0001 << ALUResult[1:0];
            st_data = {4{WriteData[7:0]}};
         end
         2'b01: begin
            st_be   = ALUResult[1] ? 4'b1100 : 4'b0011;
            st_data = {2{WriteData[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = WriteData;
         end
      endcase
   end

   // Select and extend the loaded byte/halfword using the latched access fields.
   always_comb begin
      case (acc_lo)
         2'b00:   ld_byte = mem_rdata[7:0];
         2'b01:   ld_byte = mem_rdata[15:8];
         2'b10:   ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = acc_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (acc_f3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Access latch, memory handshake outputs, timeout counter, load result and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
         ReadData  <= 32'h0;
         BusErr    <= 1'b0;
         cnt       <= '0;
         acc_f3    <= 3'b000;
         acc_lo    <= 2'b00;
      end else begin
         BusErr <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (misalign) begin
                     BusErr   <= 1'b1;
                     ReadData <= 32'h0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= MemWrite;
                     mem_addr  <= ALUResult[ADDR_WIDTH-1:2];
                     mem_be    <= st_be;
                     mem_wdata <= st_data;
                     acc_f3    <= funct3;
                     acc_lo    <= ALUResult[1:0];
                     cnt       <= '0;
                  end
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_we) begin
                     ReadData <= ld_ext;
                  end
               end else if (timeout_hit) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  BusErr   <= 1'b1;
                  ReadData <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData;
   logic        Stall, BusErr, mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Results of the last access, filled by do_access.
   int          o_stall;
   logic        o_done, o_req_seen, o_err, o_err_next, o_we;
   logic [31:0] o_rdata, o_wdata, o_addr;
   logic [3:0]  o_be;

   lsu_mem_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .BusErr(BusErr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one access from a negedge; memory answers after 'waits' req cycles. Ends on a negedge.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int waits);
      int waited;
      waited = 0;
      o_stall = 0; o_done = 1'b0; o_req_seen = 1'b0; o_err = 1'b0; o_we = 1'b0;
      o_rdata = 32'h0; o_wdata = 32'h0; o_addr = 32'h0; o_be = 4'h0;
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
      mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD;
      #1;
      for (int c = 0; c < 100 && !o_done; c++) begin
         if (c > 0) @(negedge clk);
         if (mem_req) begin
            if (!o_req_seen) begin
               o_addr = 32'(mem_addr); o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
            end
            o_req_seen = 1'b1;
            if (waited == waits) begin
               mem_ready = 1'b1; mem_rdata = rdata;
            end else begin
               mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD; waited++;
            end
         end else begin
            mem_ready = 1'b0;
         end
         if (Stall) o_stall++;
         else if (c > 0) begin
            o_done = 1'b1; o_rdata = ReadData; o_err = BusErr;
         end
      end
      MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      o_err_next = BusErr;
   endtask

   initial begin
      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
      ALUResult = 32'h0; WriteData = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_mem_req",   32'(mem_req), 0);
      check("rst_mem_we",    32'(mem_we), 0);
      check("rst_buserr",    32'(BusErr), 0);
      check("rst_stall",     32'(Stall), 0);
      check("rst_readdata",  ReadData, 0);
      check("rst_mem_addr",  32'(mem_addr), 0);
      check("rst_mem_be",    32'(mem_be), 0);
      check("rst_mem_wdata", mem_wdata, 0);

      // lw, zero wait states
      do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      check("lw_done",  32'(o_done), 1);
      check("lw_addr",  o_addr, 32'h40);
      check("lw_be",    32'(o_be), 32'hF);
      check("lw_we",    32'(o_we), 0);
      check("lw_stall", o_stall, 2);
      check("lw_rdata", o_rdata, 32'hDEADBEEF);
      check("lw_err",   32'(o_err), 0);

      // lb / lbu at byte 3, two wait states
      do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 2);
      check("lb_stall", o_stall, 4);
      check("lb_be",    32'(o_be), 32'h8);
      check("lb_rdata", o_rdata, 32'hFFFFFF80);
      do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
      check("lbu_rdata", o_rdata, 32'h00000080);

      // lh upper half, lhu lower half
      do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1);
      check("lh_stall", o_stall, 3);
      check("lh_rdata", o_rdata, 32'hFFFF80FF);
      do_access(1, 0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0);
      check("lhu_rdata", o_rdata, 32'h00001234);

      // sh at 0x22 and sb at 0x21; ReadData must keep the lhu result
      do_access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h55555555, 0);
      check("sh_addr",  o_addr, 32'h8);
      check("sh_be",    32'(o_be), 32'hC);
      check("sh_wdata", o_wdata, 32'hABCDABCD);
      check("sh_we",    32'(o_we), 1);
      check("sh_rdata", o_rdata, 32'h00001234);
      do_access(0, 1, 3'b000, 32'h21, 32'h0000005A, 32'h55555555, 1);
      check("sb_be",    32'(o_be), 32'h2);
      check("sb_wdata", o_wdata, 32'h5A5A5A5A);
      check("sb_rdata", o_rdata, 32'h00001234);

      // Timeout after 4 WAIT cycles with no ready
      do_access(1, 0, 3'b010, 32'h10, 32'h0, 32'h77777777, 1000);
      check("to_done",     32'(o_done), 1);
      check("to_req",      32'(o_req_seen), 1);
      check("to_stall",    o_stall, 5);
      check("to_err",      32'(o_err), 1);
      check("to_rdata",    o_rdata, 0);
      check("to_err_next", 32'(o_err_next), 0);

      // Late ready in IDLE is ignored
      mem_ready = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      check("late_req",   32'(mem_req), 0);
      check("late_stall", 32'(Stall), 0);
      check("late_err",   32'(BusErr), 0);
      @(negedge clk);
      check("late_rdata", ReadData, 0);
      mem_ready = 1'b0;

      // Both requests high: the store wins
      do_access(1, 1, 3'b010, 32'h44, 32'h11223344, 32'h99999999, 0);
      check("prio_we",    32'(o_we), 1);
      check("prio_addr",  o_addr, 32'h11);
      check("prio_be",    32'(o_be), 32'hF);
      check("prio_wdata", o_wdata, 32'h11223344);
      check("prio_rdata", o_rdata, 0);

      // Misaligned lw at 0x102
      do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_req",   32'(o_req_seen), 0);
      check("mis_err",   32'(o_err), 1);
      check("mis_stall", o_stall, 1);
      check("mis_rdata", o_rdata, 0);
`else
      check("mis_req",   32'(o_req_seen), 1);
      check("mis_addr",  o_addr, 32'h40);
      check("mis_be",    32'(o_be), 32'hF);
      check("mis_err",   32'(o_err), 0);
      check("mis_rdata", o_rdata, 32'hCAFEF00D);
`endif

      // Reset asserted while waiting on memory
      MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h200;
      @(negedge clk);
      check("rstw_req", 32'(mem_req), 1);
      rst_n = 1'b0; MemRead = 1'b0;
      #1;
      check("rstw_async_req", 32'(mem_req), 0);
      check("rstw_stall",     32'(Stall), 0);
      check("rstw_rdata",     ReadData, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstw_idle_req",   32'(mem_req), 0);
      check("rstw_idle_stall", 32'(Stall), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

- Load/store unit between the datapath and a variable-latency, word-addressed data memory.
- Takes the ALU-computed address, store data and funct3, and drives a req/ready memory handshake with byte enables.
- Stalls the core for the duration of each access.
- Returns the sign- or zero-extended load value on `ReadData`, the data input to the writeback result mux (ResultSrc = 01).

## Interface
- `ADDR_WIDTH`, 32, byte-address width; the memory word address is `ADDR_WIDTH-2` bits.
- `TIMEOUT_CYCLES`, 255, maximum cycles to wait for `mem_ready` before aborting; must be ≥ 1.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request; has priority when both requests are high.
- `funct3` input 3: access size and extension (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `ALUResult` input ADDR_WIDTH: byte address.
- `WriteData` input 32: store data (rs2).
- `ReadData` output 32: extended load result.
- `Stall` output 1: core must hold PC and all state while high.
- `BusErr` output 1: one-cycle pulse, access timed out.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write strobe.
- `mem_addr` output ADDR_WIDTH-2: word address.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ready` input 1: memory completes the access in this cycle.
- `mem_rdata` input 32: read word, valid when `mem_ready` is high.

## Operation
- **States:** IDLE, WAIT, DONE.
- **IDLE**
  - If `MemWrite` or `MemRead` is high: latch the access, go to WAIT.
  - Latched fields: address, funct3, write flag, lane-shifted data, enables.
  - Otherwise stay in IDLE.
- **WAIT**
  - `mem_req`=1, and all mem_* outputs are held stable.
  - `mem_ready`=1: capture the extended `mem_rdata` into `ReadData` (loads only), go to DONE.
  - Timeout counter reaching `TIMEOUT_CYCLES`: force `ReadData`=0, pulse `BusErr`, go to DONE.
- **DONE:** `Stall`=0 for exactly one cycle, then unconditionally return to IDLE. DONE never re-triggers on the still-high request.
- **Stall** = (IDLE and (`MemRead` or `MemWrite`)) or WAIT. It is combinational.
- **Store enables and data:**
  - sb: `mem_be` = 0001 << addr[1:0], byte replicated 4x.
  - sh: `mem_be` = 0011 << (2·addr[1]), halfword replicated 2x.
  - sw and undefined funct3 (011, 110, 111): `mem_be` = 1111.
- **Load extension:**
  - lb/lh sign-extend the selected byte/half, selected by addr[1:0] / addr[1].
  - lbu/lhu zero-extend.
  - lw and undefined funct3 pass the full word.
- **Unchanged values:** `ReadData` holds its last value until the next completed load. Stores leave it unchanged.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `BusErr` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `ReadData` = 0; timeout counter 0.
- **Reset mid-access:** `mem_req` deasserts asynchronously and the access is dropped with no retry.
- **Minimum latency:** request seen in cycle 0, `mem_req` high in cycle 1, `mem_ready` in cycle 1, DONE in cycle 2. The core advances at the end of cycle 2, so 3 cycles per access.
- **Memory wait states:** each cycle `mem_ready` stays low adds one cycle.
- **Timeout:** the counter starts at 0 on WAIT entry and increments each WAIT cycle. The abort takes effect after `TIMEOUT_CYCLES` cycles in WAIT without `mem_ready`.
- **Late ready:** `mem_ready` outside WAIT is ignored.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - An h access with addr[0]=1, or a w access with addr[1:0]≠00, is misaligned.
  - A misaligned access skips the memory (no `mem_req`), goes IDLE to DONE directly, pulses `BusErr` in DONE, and yields `ReadData`=0.
- **Not defined:**
  - The offending low address bits are treated as 0: halfword at addr & ~1, word at addr & ~3.
  - No error is raised.

## Test plan
- **lw, zero wait states:** addr 0x100, `mem_rdata`=0xDEADBEEF with immediate ready. Expect `mem_addr`=0x40, `mem_be`=1111, `Stall` high for 2 cycles, `ReadData`=0xDEADBEEF in DONE.
- **lb / lbu:** addr 0x103, `mem_rdata`=0x80FF1234, 2 wait states. lb gives `ReadData`=0xFFFFFF80; lbu gives 0x00000080; `Stall` high for 4 cycles.
- **sh:** addr 0x22, `WriteData`=0x0000ABCD. Expect `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1, `ReadData` unchanged.
- **Timeout:** `TIMEOUT_CYCLES`=4, `mem_ready` never asserted. Expect a one-cycle `BusErr` pulse, `ReadData`=0, return to IDLE, and a late `mem_ready` ignored.
- **Priority and reset:**
  - `MemRead`=`MemWrite`=1: the store is performed.
  - `rst_n` low during WAIT: `mem_req` drops asynchronously; state IDLE.
- **Misaligned lw at 0x102:**
  - With `LSU_MISALIGN_TRAP_EN`: no `mem_req`, `BusErr` pulse.
  - Without it: `mem_addr`=0x40, word access.
